// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: control inputs from hazard/branch logic, the
// combinational program-ROM address/data pair, and the IF/ID register outputs.
//   master : the fetch unit (drives PC, ROM address, IF/ID, fault status)
//   slave  : the environment (hazard unit, branch/jump resolution, ROM)
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall_i;
  logic                  Branch_i;
  logic [DATA_WIDTH-1:0] BranchTarget_i;
  logic                  Jump_i;
  logic [DATA_WIDTH-1:0] JumpTarget_i;
  logic [DATA_WIDTH-1:0] MemInstruction_i;
  logic [DATA_WIDTH-1:0] MemAddress_o;
  logic [DATA_WIDTH-1:0] PC_o;
  logic [DATA_WIDTH-1:0] IFID_Instruction_o;
  logic [DATA_WIDTH-1:0] IFID_PC4_o;
  logic                  IFID_Valid_o;
  logic                  Fault_o;
  logic [DATA_WIDTH-1:0] FaultPC_o;

  modport master (
    input  Stall_i, Branch_i, BranchTarget_i, Jump_i, JumpTarget_i, MemInstruction_i,
    output MemAddress_o, PC_o, IFID_Instruction_o, IFID_PC4_o, IFID_Valid_o,
           Fault_o, FaultPC_o
  );

  modport slave (
    output Stall_i, Branch_i, BranchTarget_i, Jump_i, JumpTarget_i, MemInstruction_i,
    input  MemAddress_o, PC_o, IFID_Instruction_o, IFID_PC4_o, IFID_Valid_o,
           Fault_o, FaultPC_o
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage sequencer. Owns the PC, presents it to a combinational program
// ROM and registers the returned word plus PC+4 into the IF/ID register.
// Handles stall, jump/branch redirect (with IF/ID squash) and traps fetch
// addresses that are misaligned or outside the ROM window.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   bus   : instruction_fetch_unit_if.master (controls, ROM, IF/ID, fault)
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_RESET     = DATA_WIDTH'(32'h0040_0000)
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc4;
    logic                  valid;
  } ifid_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  ifid_t                 ifid_q, ifid_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] cand;
  logic                  load;

  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // Offset from base is unsigned, so addresses below PC_RESET wrap to huge
  // values and fail the depth compare as well.
  function automatic logic bad_addr(input logic [DATA_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] off;
    off = a - PC_RESET;
    return (a[1:0] != 2'b00) || ((off >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= PC_RESET;
      ifid_q  <= '0;
      fault_q <= 1'b0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
      fpc_q   <= fpc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fault_q;
    fpc_d   = fpc_q;
    cand    = pc_plus4;
    load    = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Redirects override stall; jump outranks branch.
        if (bus.Jump_i || bus.Branch_i) begin
          cand   = bus.Jump_i ? bus.JumpTarget_i : bus.BranchTarget_i;
          ifid_d = '0;
          load   = 1'b1;
        end else if (!bus.Stall_i) begin
          cand   = pc_plus4;
          ifid_d = '{instr: bus.MemInstruction_i, pc4: pc_plus4, valid: 1'b1};
          load   = 1'b1;
        end
        // A bad next-PC traps; the IF/ID update above still takes effect.
        if (load) begin
          if (bad_addr(cand)) begin
            fault_d = 1'b1;
            fpc_d   = cand;
            state_d = HALT;
          end else begin
            pc_d = cand;
          end
        end
      end
      HALT: ifid_d.valid = 1'b0;
      default: state_d = BOOT;
    endcase
  end

  assign bus.MemAddress_o       = pc_q;
  assign bus.PC_o               = pc_q;
  assign bus.IFID_Instruction_o = ifid_q.instr;
  assign bus.IFID_PC4_o         = ifid_q.pc4;
  assign bus.IFID_Valid_o       = ifid_q.valid;
  assign bus.Fault_o            = fault_q;
  assign bus.FaultPC_o          = fpc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The stimulus process drives one
// cycle at a time and queues the hand-computed post-edge state; a separate
// monitor pops and compares on the falling edge.
module tb_instruction_fetch_unit;
  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct {
    int          id;
    logic [31:0] pc, instr, pc4, fpc;
    logic        v, f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rom [32];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          stepn = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

  instruction_fetch_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .PC_RESET(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational ROM; out-of-window reads return 0.
  logic [31:0] rom_off;
  assign rom_off = bus.MemAddress_o - BASE;
  assign bus.MemInstruction_i = (rom_off[31:2] < 30'd32) ? rom[rom_off[6:2]] : 32'h0;

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: one queued expectation per clock, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "pc",      bus.PC_o,               e.pc);
      chk(e.id, "memaddr", bus.MemAddress_o,       e.pc);
      chk(e.id, "valid",   {31'b0, bus.IFID_Valid_o}, {31'b0, e.v});
      chk(e.id, "instr",   bus.IFID_Instruction_o, e.instr);
      chk(e.id, "pc4",     bus.IFID_PC4_o,         e.pc4);
      chk(e.id, "fault",   {31'b0, bus.Fault_o},   {31'b0, e.f});
      chk(e.id, "faultpc", bus.FaultPC_o,          e.fpc);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt,
                     input logic [31:0] pc, input logic v, input logic [31:0] instr,
                     input logic [31:0] pc4, input logic f, input logic [31:0] fpc);
    exp_t e;
    reset = r; bus.Stall_i = s; bus.Branch_i = b; bus.BranchTarget_i = bt;
    bus.Jump_i = j; bus.JumpTarget_i = jt;
    @(posedge clk);
    #1;
    stepn++;
    e.id = stepn; e.pc = pc; e.v = v; e.instr = instr; e.pc4 = pc4; e.f = f; e.fpc = fpc;
    exp_q.push_back(e);
  endtask

  // Plain sequential cycle, no fault.
  task automatic run(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pc4);
    cyc(1, 0, 0, 0, 0, 0, pc, 1, instr, pc4, 0, 0);
  endtask

  initial begin
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0003;
    for (int i = 2; i < 32; i++) rom[i] = 32'hAB00_0000 | i;
    bus.Stall_i = 0; bus.Branch_i = 0; bus.BranchTarget_i = 0;
    bus.Jump_i = 0; bus.JumpTarget_i = 0;

    // Reset, then BOOT cycle holds PC with IF/ID invalid.
    cyc(0, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    run(32'h0040_0004, 32'h2008_0005, 32'h0040_0004);
    run(32'h0040_0008, 32'h2009_0003, 32'h0040_0008);
    // Stall three cycles at 0x0040_0008, then word2.
    for (int k = 0; k < 3; k++)
      cyc(1, 1, 0, 0, 0, 0, 32'h0040_0008, 1, 32'h2009_0003, 32'h0040_0008, 0, 0);
    run(32'h0040_000C, 32'hAB00_0002, 32'h0040_000C);
    // Jump beats branch and stall; squash.
    cyc(1, 1, 1, 32'h0040_0010, 1, 32'h0040_0020, 32'h0040_0020, 0, 0, 0, 0, 0);
    run(32'h0040_0024, 32'hAB00_0008, 32'h0040_0024);
    run(32'h0040_0028, 32'hAB00_0009, 32'h0040_0028);
    // Branch alone redirects.
    cyc(1, 0, 1, 32'h0040_0010, 0, 0, 32'h0040_0010, 0, 0, 0, 0, 0);
    run(32'h0040_0014, 32'hAB00_0004, 32'h0040_0014);
    // Misaligned branch traps; PC holds, squash still happens.
    cyc(1, 0, 1, 32'h0040_0006, 0, 0, 32'h0040_0014, 0, 0, 0, 1, 32'h0040_0006);
    // HALT ignores jump, branch and stall.
    cyc(1, 0, 0, 0, 1, 32'h0040_0040, 32'h0040_0014, 0, 0, 0, 1, 32'h0040_0006);
    cyc(1, 1, 1, 32'h0040_0008, 0, 0, 32'h0040_0014, 0, 0, 0, 1, 32'h0040_0006);
    // One-cycle reset out of HALT, BOOT, then sequential to the end of ROM.
    cyc(0, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 31; k++)
      run(BASE + 32'(4 * k), rom[k - 1], BASE + 32'(4 * k));
    // Fetch of word31 wants PC 0x0040_0080: word delivered, then trap.
    cyc(1, 0, 0, 0, 0, 0, 32'h0040_007C, 1, rom[31], 32'h0040_0080, 1, 32'h0040_0080);
    cyc(1, 0, 0, 0, 0, 0, 32'h0040_007C, 0, rom[31], 32'h0040_0080, 1, 32'h0040_0080);
    // Below-base jump target underflows the range check.
    cyc(0, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, BASE, 0, 0, 0, 0, 0);
    run(32'h0040_0004, 32'h2008_0005, 32'h0040_0004);
    cyc(1, 0, 0, 0, 1, 32'h003F_FFFC, 32'h0040_0004, 0, 0, 0, 1, 32'h003F_FFFC);
    cyc(1, 0, 0, 0, 0, 0, 32'h0040_0004, 0, 0, 0, 1, 32'h003F_FFFC);

    bus.Jump_i = 0; bus.Branch_i = 0; bus.Stall_i = 0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-stage sequencer for the MIPS core. It owns the program counter and drives the Address input of the combinational program ROM. It registers the returned instruction into the IF/ID pipeline register. It handles sequential fetch, stalls, jump/branch redirects with squash, and traps misaligned or out-of-range fetch addresses.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instructions
MEMORY_DEPTH, 32, number of words in program ROM; used for range check
PC_RESET, 32'h0040_0000, PC value after reset (text segment base)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
Stall_i  input  1  hazard unit: hold PC and IF/ID
Branch_i  input  1  taken branch resolved this cycle
BranchTarget_i  input  DATA_WIDTH  branch destination byte address
Jump_i  input  1  jump resolved this cycle
JumpTarget_i  input  DATA_WIDTH  jump destination byte address
MemInstruction_i  input  DATA_WIDTH  instruction returned by ROM for MemAddress_o
MemAddress_o  output  DATA_WIDTH  byte address to ROM; equals PC_o (combinational)
PC_o  output  DATA_WIDTH  current program counter
IFID_Instruction_o  output  DATA_WIDTH  registered instruction
IFID_PC4_o  output  DATA_WIDTH  registered PC+4 of that instruction
IFID_Valid_o  output  1  IF/ID holds a real instruction
Fault_o  output  1  sticky fetch-fault flag
FaultPC_o  output  DATA_WIDTH  offending address captured at fault

Behaviour:
- Reset (reset==0 at clk edge) has priority over everything:
  - PC=PC_RESET; IFID_Instruction=0 (NOP); IFID_PC4=0; IFID_Valid=0; Fault=0; FaultPC=0; state=BOOT.
- The ROM is combinational: MemInstruction_i is valid in the same cycle MemAddress_o is presented. Fetch latency is 1 clk from PC to IF/ID.
- States:
  - BOOT: one cycle. PC holds; IF/ID stays invalid; go RUN. This absorbs the ROM settling after reset release.
  - RUN: normal operation, per-cycle priority below.
  - HALT: PC, IF/ID frozen; IFID_Valid=0; leave only by reset.
- RUN priority per cycle (highest first):
  1. Jump_i: PC<=JumpTarget_i; IF/ID squashed (Instruction=0, Valid=0, PC4=0). Applies even if Stall_i=1.
  2. Branch_i: same as jump with BranchTarget_i. If Jump_i and Branch_i are both asserted, the jump wins.
  3. Stall_i: PC and all IF/ID outputs hold their values.
  4. Otherwise: IF/ID<=MemInstruction_i, PC+4, Valid=1; PC<=PC+4.
- PC+4 wraps modulo 2^DATA_WIDTH with no flag; the range check below catches it.
- Fault check applies to the next PC value (target or PC+4) before loading. Fault if either:
  - next[1:0]!=0 (misaligned), or
  - (next-PC_RESET)>>2 >= MEMORY_DEPTH (unsigned; below-base addresses underflow and also fault).
- On fault:
  - Fault_o<=1; FaultPC_o<=offending address; PC is not updated; state<=HALT.
  - The IF/ID load of the current cycle still occurs for the sequential case (valid instruction delivered). For redirects the squash still occurs.
- Fault_o and FaultPC_o stay constant in HALT. Stall_i, Branch_i and Jump_i are ignored in HALT and BOOT.
- Reset mid-operation (any state) returns to BOOT next cycle with the reset values above.
- No combinational path from Stall_i, Branch_i or Jump_i to any output. All outputs except MemAddress_o are registered.

Test Plan:
- Reset then release, ROM word0=0x2008_0005, word1=0x2009_0003:
  - cycle0 after release (BOOT): PC=0x0040_0000, Valid=0.
  - cycle1: IF/ID=0x2008_0005, PC4=0x0040_0004, Valid=1, PC=0x0040_0004.
- Stall_i=1 for 3 cycles at PC=0x0040_0008 -> PC and IF/ID unchanged for 3 cycles, then resume with word2.
- Jump_i=1 with JumpTarget=0x0040_0020 while Stall_i=1 and Branch_i=1 (BranchTarget=0x0040_0010):
  - next cycle PC=0x0040_0020, Valid=0.
  - following cycle IF/ID=word8, PC4=0x0040_0024.
- Branch to 0x0040_0006 -> Fault_o=1, FaultPC_o=0x0040_0006, PC unchanged, Valid=0, state HALT; later Jump_i has no effect.
- Sequential run to PC=0x0040_007C (word31, MEMORY_DEPTH=32):
  - word31 delivered with Valid=1.
  - Fault_o=1 with FaultPC_o=0x0040_0080; PC stays 0x0040_007C.
- reset=0 asserted for one cycle during HALT -> Fault_o=0, PC=0x0040_0000, BOOT, then word0 fetched normally.
